// File: rtl/modbus_rtu_tx.sv
`default_nettype none
// ============================================================================
// modbus_rtu_tx : Modbus RTU frame serializer; appends CRC-16, enforces silence
// Revision      : 1.0
// ============================================================================
module modbus_rtu_tx #(
   parameter int SILENCE_CYCLES = 40,
   parameter int MAX_PAYLOAD    = 254
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] inData,
   input  logic       inValid,
   input  logic       inLast,
   output logic       inReady,
   output logic [7:0] outData,
   output logic       outReq,
   input  logic       outAck,
   output logic       busy,
   output logic       overflow
);
   localparam int         GAP_W   = (SILENCE_CYCLES > 1) ? $clog2(SILENCE_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_END = GAP_W'(SILENCE_CYCLES - 1);
   localparam logic [7:0] MAX_CNT = 8'(MAX_PAYLOAD);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DATA   = 3'd1,
      CRC_LO = 3'd2,
      CRC_HI = 3'd3,
      GAP    = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [7:0]       data_q, data_d;
   logic             req_q, req_d;
   logic [15:0]      crc_q, crc_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             last_q, last_d;
   logic             ovf_q, ovf_d;
   logic             ready;
   logic             accept;
   logic             is_last;
   logic [7:0]       cnt_next;

   function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
      logic [15:0] c;
      c = crc ^ {8'h00, b};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
      end
      return c;
   endfunction

   always_comb begin
      ready = 1'b0;
      if (state_q == IDLE) begin
         ready = 1'b1;
      end else if (state_q == DATA) begin
         ready = !req_q && !last_q;
      end
   end

   assign inReady  = rst & ready;
   assign accept   = inValid & inReady;
   assign cnt_next = cnt_q + 8'd1;
   // Reaching the payload limit closes the frame even without inLast.
   assign is_last  = inLast || (cnt_next == MAX_CNT);

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      req_d   = req_q;
      crc_d   = crc_q;
      cnt_d   = cnt_q;
      gap_d   = gap_q;
      last_d  = last_q;
      ovf_d   = 1'b0;
      if (accept) begin
         state_d = DATA;
         data_d  = inData;
         req_d   = 1'b1;
         cnt_d   = cnt_next;
         last_d  = is_last;
         crc_d   = crc16_byte(crc_q, inData);
         ovf_d   = (cnt_next == MAX_CNT) && !inLast;
      end
      case (state_q)
         DATA: begin
            if (req_q && outAck) begin
               req_d = 1'b0;
               if (last_q) begin
                  state_d = CRC_LO;
               end
            end
         end
         // Each CRC byte is raised one cycle after the previous ack, like payload.
         CRC_LO: begin
            if (!req_q) begin
               req_d  = 1'b1;
               data_d = crc_q[7:0];
            end else if (outAck) begin
               req_d   = 1'b0;
               state_d = CRC_HI;
            end
         end
         CRC_HI: begin
            if (!req_q) begin
               req_d  = 1'b1;
               data_d = crc_q[15:8];
            end else if (outAck) begin
               req_d   = 1'b0;
               gap_d   = '0;
               state_d = GAP;
            end
         end
         GAP: begin
            gap_d = gap_q + GAP_W'(1);
            if (gap_q == GAP_END) begin
               state_d = IDLE;
               gap_d   = '0;
               crc_d   = 16'hFFFF;
               cnt_d   = 8'd0;
               last_d  = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         data_q  <= 8'h00;
         req_q   <= 1'b0;
         crc_q   <= 16'hFFFF;
         cnt_q   <= 8'd0;
         gap_q   <= '0;
         last_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         req_q   <= req_d;
         crc_q   <= crc_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
         last_q  <= last_d;
         ovf_q   <= ovf_d;
      end
   end

   assign outData  = data_q;
   assign outReq   = rst & req_q;
   assign busy     = rst & (state_q != IDLE);
   assign overflow = rst & ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_modbus_rtu_tx.sv
`default_nettype none
// ============================================================================
// tb_modbus_rtu_tx : randomized bench with frame-level reference model
// Revision         : 1.0
// ============================================================================
module tb_modbus_rtu_tx;
   localparam int SIL  = 40;
   localparam int MAXP = 254;

   typedef struct packed {
      logic       last;
      logic [7:0] data;
   } tok_t;

   logic       clk     = 1'b0;
   logic       rst     = 1'b0;
   logic [7:0] inData  = 8'h00;
   logic       inValid = 1'b0;
   logic       inLast  = 1'b0;
   logic       outAck  = 1'b0;
   logic       inReady;
   logic [7:0] outData;
   logic       outReq;
   logic       busy;
   logic       overflow;

   always #5 clk = ~clk;

   modbus_rtu_tx #(
      .SILENCE_CYCLES (SIL),
      .MAX_PAYLOAD    (MAXP)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .inData   (inData),
      .inValid  (inValid),
      .inLast   (inLast),
      .inReady  (inReady),
      .outData  (outData),
      .outReq   (outReq),
      .outAck   (outAck),
      .busy     (busy),
      .overflow (overflow)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Bit-serial LFSR form of the Modbus CRC over a whole message.
   function automatic logic [15:0] ref_crc(input logic [7:0] msg[$]);
      logic [15:0] crc;
      logic        fb;
      crc = 16'hFFFF;
      foreach (msg[i]) begin
         for (int b = 0; b < 8; b++) begin
            fb  = crc[0] ^ msg[i][b];
            crc = crc >> 1;
            if (fb) crc = crc ^ 16'hA001;
         end
      end
      return crc;
   endfunction

   tok_t       offer_q[$];
   logic [7:0] exp_q[$];
   logic [7:0] frame_buf[$];
   logic [7:0] got_q[$];
   int         frame_end_idx[$];
   int         push_cnt = 0, out_cnt = 0, cyc = 0;
   int         gap_start = -1, gap_ack_cyc = -1, gap_len_n = 0;
   int         ovf_seen = 0;
   bit         ovf_exp = 0, cont_mode = 0;
   bit         prev_req = 0, prev_ack = 0, prev_rst = 0;
   logic [7:0] prev_data = 8'h00;
   int         valid_pct = 100, ack_pct = 50, ack_delay = 0, req_age = 0;

   task automatic model_accept(input tok_t t);
      logic [15:0] c;
      frame_buf.push_back(t.data);
      exp_q.push_back(t.data);
      push_cnt++;
      if (frame_buf.size() == MAXP && !t.last) ovf_exp = 1;
      if (t.last || frame_buf.size() == MAXP) begin
         c = ref_crc(frame_buf);
         exp_q.push_back(c[7:0]);
         exp_q.push_back(c[15:8]);
         push_cnt += 2;
         frame_end_idx.push_back(push_cnt - 1);
         frame_buf.delete();
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (offer_q.size() > 0 && $urandom_range(99) < valid_pct) begin
         inValid = 1'b1;
         inData  = offer_q[0].data;
         inLast  = offer_q[0].last;
      end else begin
         inValid = 1'b0;
         inData  = 8'($urandom);
         inLast  = 1'($urandom);
      end
      if (outReq) req_age++;
      else        req_age = 0;
      if (ack_delay > 0) outAck = (req_age == ack_delay + 1);
      else               outAck = ($urandom_range(99) < ack_pct);
   end

   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         check("rst_outReq", outReq, 0);
         check("rst_busy", busy, 0);
         check("rst_overflow", overflow, 0);
         check("rst_inReady", inReady, 0);
         offer_q.delete();
         exp_q.delete();
         frame_buf.delete();
         frame_end_idx.delete();
         push_cnt    = out_cnt;
         gap_start   = -1;
         gap_ack_cyc = -1;
         ovf_exp     = 0;
         prev_req    = 0;
         prev_ack    = 0;
         prev_rst    = 0;
      end else begin
         if (!prev_rst) begin
            check("rel_outData", outData, 8'h00);
            check("rel_outReq", outReq, 0);
            check("rel_busy", busy, 0);
            check("rel_inReady", inReady, 1);
         end else begin
            if (prev_req && !prev_ack) begin
               check("req_hold", outReq, 1);
               check("data_hold", outData, prev_data);
            end
            if (prev_req && prev_ack) check("req_drop", outReq, 0);
         end
         check("overflow", overflow, ovf_exp);
         ovf_exp = 0;
         if (overflow) ovf_seen++;
         if (gap_start >= 0) begin
            if (cyc - gap_start <= SIL) begin
               check("gap_ready", inReady, 0);
            end else begin
               check("gap_end_ready", inReady, 1);
               check("gap_end_busy", busy, 0);
               gap_start = -1;
            end
         end
         if (outReq && outAck) begin
            if (exp_q.size() == 0) check("extra_out", 1, 0);
            else                   check("out_byte", outData, exp_q.pop_front());
            got_q.push_back(outData);
            if (frame_end_idx.size() > 0 && frame_end_idx[0] == out_cnt) begin
               void'(frame_end_idx.pop_front());
               gap_start = cyc;
               if (cont_mode) gap_ack_cyc = cyc;
            end
            out_cnt++;
         end
         if (inValid && inReady) begin
            if (offer_q.size() == 0) begin
               check("phantom_accept", 1, 0);
            end else begin
               if (cont_mode && gap_ack_cyc >= 0) begin
                  check("gap_len", cyc - gap_ack_cyc, SIL + 1);
                  gap_len_n++;
                  gap_ack_cyc = -1;
               end
               model_accept(offer_q.pop_front());
            end
         end
         prev_req  = outReq;
         prev_ack  = outAck;
         prev_data = outData;
         prev_rst  = 1;
      end
   end

   task automatic push(input logic [7:0] d, input bit l);
      offer_q.push_back({l, d});
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n;
      n = 0;
      while (n < budget && (offer_q.size() != 0 || exp_q.size() != 0 || gap_start >= 0 || busy)) begin
         @(negedge clk);
         #2;
         n++;
      end
      check({tag, "_done"}, (n < budget), 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int         base, n, ov0, total;
      logic [7:0] rb[$];
      logic [7:0] f1[$];
      logic [7:0] f2[$];
      f1 = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01};
      f2 = '{8'h37, 8'h01, 8'h00, 8'h00, 8'hA5, 8'hFF, 8'h02, 8'h8C};

      repeat (3) @(posedge clk);
      #2 rst = 1'b1;

      // Reference frame, ack one cycle after each request
      valid_pct = 100; ack_delay = 1;
      base = got_q.size();
      foreach (f1[i]) push(f1[i], i == 5);
      wait_done("t1", 500);
      check("t1_len", got_q.size() - base, 8);
      if (got_q.size() >= base + 8) begin
         check("t1_crc_lo", got_q[base+6], 8'h84);
         check("t1_crc_hi", got_q[base+7], 8'h0A);
      end

      // Slow acknowledger
      ack_delay = 5;
      base = got_q.size();
      foreach (f2[i]) push(f2[i], i == 7);
      wait_done("t2", 1000);
      check("t2_len", got_q.size() - base, 10);

      // Two identical frames offered back to back
      ack_delay = 0; ack_pct = 50; cont_mode = 1; gap_len_n = 0;
      rb.delete();
      for (int i = 0; i < 5; i++) rb.push_back(8'($urandom));
      base = got_q.size();
      for (int k = 0; k < 2; k++) foreach (rb[i]) push(rb[i], i == 4);
      wait_done("t3", 1000);
      cont_mode = 0; gap_ack_cyc = -1;
      check("t3_len", got_q.size() - base, 14);
      check("t3_gap_measured", gap_len_n, 1);
      if (got_q.size() >= base + 14) begin
         check("t3_crc_repeat_lo", got_q[base+12], got_q[base+5]);
         check("t3_crc_repeat_hi", got_q[base+13], got_q[base+6]);
      end

      // Truncation at the payload limit, back-to-back acks
      ack_pct = 100; ov0 = ovf_seen;
      base = got_q.size();
      for (int i = 0; i < 255; i++) push(8'($urandom), 1'b0);
      push(8'($urandom), 1'b1);
      wait_done("t4", 3000);
      check("t4_ovf_count", ovf_seen - ov0, 1);
      check("t4_len", got_q.size() - base, 260);

      // Reset after three bytes of a frame
      ack_pct = 50;
      for (int i = 0; i < 6; i++) push(8'($urandom), i == 5);
      n = 0;
      while (n < 200 && frame_buf.size() != 3) begin
         @(negedge clk);
         #2;
         n++;
      end
      check("t5_three_accepted", (n < 200), 1);
      @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      base = got_q.size();
      foreach (f1[i]) push(f1[i], i == 5);
      wait_done("t5", 500);
      check("t5_len", got_q.size() - base, 8);
      if (got_q.size() >= base + 8) begin
         check("t5_crc_lo", got_q[base+6], 8'h84);
         check("t5_crc_hi", got_q[base+7], 8'h0A);
      end

      // Random frames with stalls and spurious acks
      valid_pct = 60; ack_pct = 40; total = 0;
      base = got_q.size();
      for (int f = 0; f < 12; f++) begin
         n = (f == 0) ? 1 : $urandom_range(10, 1);
         for (int i = 0; i < n; i++) push(8'($urandom), i == n - 1);
         total += n + 2;
      end
      wait_done("t6", 5000);
      check("t6_len", got_q.size() - base, total);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/modbus_rtu_tx.md
MODBUS_RTU_TX -- requirements
Module: modbus_rtu_tx

Interface
REQ-001 Parameter SILENCE_CYCLES, default 40, SHALL set the idle clk cycles enforced after each frame's last CRC byte (Modbus 3.5-char gap).
REQ-002 Parameter MAX_PAYLOAD, default 254, SHALL set the maximum payload bytes per frame, CRC excluded.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 inData  in  8  payload byte (address, function, data) from response builder.
REQ-006 inValid  in  1  inData/inLast valid.
REQ-007 inLast  in  1  qualifies the final payload byte of a frame.
REQ-008 inReady  out  1  byte accepted on an edge where inValid & inReady.
REQ-009 outData  out  8  byte to UART transmitter.
REQ-010 outReq  out  1  outData valid, held until acknowledged.
REQ-011 outAck  in  1  UART took outData; sampled only while outReq=1.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 overflow  out  1  one-cycle pulse when a frame is truncated at MAX_PAYLOAD.

Function
REQ-014 States SHALL be IDLE, DATA, CRC_LO, CRC_HI, GAP; one byte in flight at most.
REQ-015 inReady SHALL be combinational: 1 in IDLE; 1 in DATA iff outReq=0 and last byte not yet accepted; 0 in CRC_LO, CRC_HI, GAP.
REQ-016 Accepting a byte at edge k SHALL present it on outData with outReq=1 from cycle k+1; IDLE -> DATA on first accepted byte.
REQ-017 outReq and outData SHALL stay stable until an edge with outAck=1; outReq SHALL be 0 in the following cycle; outAck while outReq=0 SHALL be ignored.
REQ-018 CRC SHALL be Modbus CRC-16: init 0xFFFF at each frame start, reflected poly 0xA001, one full byte update per accepted byte, no final XOR.
REQ-019 After the acked last payload byte: DATA -> CRC_LO, outReq=1, outData=crc[7:0] next cycle; on its ack -> CRC_HI, outData=crc[15:8]; on its ack -> GAP.
REQ-020 GAP SHALL hold inReady=0 for exactly SILENCE_CYCLES cycles after the CRC_HI ack edge, then enter IDLE; earliest next accept is SILENCE_CYCLES+1 cycles after that edge.
REQ-021 A payload counter (8 bits) SHALL count accepted bytes; the MAX_PAYLOAD-th byte SHALL be treated as last regardless of inLast, pulsing overflow for one cycle at its accept edge if inLast=0.
REQ-022 Frame-end detection SHALL use inLast only at accept edges; inLast without inValid SHALL be ignored.
REQ-023 inValid may drop mid-frame; DATA SHALL wait indefinitely with outReq=0 and no CRC change.
REQ-024 Single-byte frame (inLast on first byte) SHALL emit 1 payload + 2 CRC bytes.
REQ-025 Back-to-back ack (outAck=1 in the first cycle of outReq) SHALL be legal; throughput bound = 1 byte per 2 cycles.

Reset
REQ-026 rst=0 at an edge SHALL force: state IDLE, outReq=0, outData=0x00, inReady=1 after release, busy=0, overflow=0, CRC=0xFFFF, counter=0, gap counter=0.
REQ-027 Reset mid-frame SHALL discard the frame; no partial CRC emitted; no GAP enforced after release.
REQ-028 Outputs during reset: outReq=0, busy=0, overflow=0, inReady=0.

Verification
REQ-029 Frame 01 03 00 00 00 01 (inLast on 6th), outAck one cycle after each outReq -> outData sequence 01 03 00 00 00 01 84 0A, then busy=0 after GAP.
REQ-030 Frame 37 01 00 00 A5 FF 02 8C with outAck delayed 5 cycles each -> 8 payload bytes unchanged, outData stable while outReq=1, 10 bytes total, CRC = software Modbus CRC of payload low byte first.
REQ-031 Second frame offered continuously right after first -> inReady=0 for exactly SILENCE_CYCLES cycles after CRC_HI ack; first byte of frame 2 accepted at SILENCE_CYCLES+1; CRC restarts at 0xFFFF (identical frames give identical CRC).
REQ-032 255 bytes offered with inLast never set, MAX_PAYLOAD=254 -> overflow pulses once at byte 254, CRC of 254 bytes follows, byte 255 held until after GAP.
REQ-033 rst=0 asserted after 3 bytes of a frame -> outReq=0 next cycle, no CRC bytes; new frame 01 03 00 00 00 01 post-reset accepted immediately and ends 84 0A.
REQ-034 Spurious outAck=1 while outReq=0 and inValid toggled mid-frame -> no byte skipped or duplicated; output stream equals payload + correct CRC.
